// File: rtl/l2_port_arbiter.sv
// N-port arbiter between the L1 caches and the shared L2: registered request capture,
// round-robin or fixed-priority selection, one outstanding downstream transaction.
module l2_port_arbiter #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 128,
    parameter bit          RR_MODE    = 1'b1,
    localparam int unsigned GW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [NUM_PORTS-1:0]             req_read_i,
    input  logic [NUM_PORTS-1:0]             req_write_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata_i,
    output logic [NUM_PORTS-1:0]             req_resp_o,
    output logic [LINE_WIDTH-1:0]            req_rdata_o,
    output logic                             dn_read_o,
    output logic                             dn_write_o,
    output logic [ADDR_WIDTH-1:0]            dn_addr_o,
    output logic [LINE_WIDTH-1:0]            dn_wdata_o,
    input  logic [LINE_WIDTH-1:0]            dn_rdata_i,
    input  logic                             dn_resp_i,
    output logic                             busy_o,
    output logic [GW-1:0]                    grant_id_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e                  state_q, state_d;
    logic [GW-1:0]           ptr_q, ptr_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic                    dn_read_q, dn_read_d;
    logic                    dn_write_q, dn_write_d;
    logic [ADDR_WIDTH-1:0]   dn_addr_q, dn_addr_d;
    logic [LINE_WIDTH-1:0]   dn_wdata_q, dn_wdata_d;
    logic [LINE_WIDTH-1:0]   rdata_q, rdata_d;
    logic [NUM_PORTS-1:0]    resp_q, resp_d;

    logic [NUM_PORTS-1:0]    req_any;
    logic [GW-1:0]           win;
    logic                    win_vld;
    logic                    win_rd, win_wr;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [LINE_WIDTH-1:0]   win_wdata;

    assign req_any = req_read_i | req_write_i;

    // Scan from the far end so the last hit is the highest-priority requester.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        if (RR_MODE) begin
            for (int off = int'(NUM_PORTS); off >= 1; off--) begin
                if (req_any[GW'((int'(ptr_q) + off) % int'(NUM_PORTS))]) begin
                    win     = GW'((int'(ptr_q) + off) % int'(NUM_PORTS));
                    win_vld = 1'b1;
                end
            end
        end else begin
            for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
                if (req_any[GW'(i)]) begin
                    win     = GW'(i);
                    win_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        win_rd    = 1'b0;
        win_wr    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (GW'(i) == win) begin
                win_rd    = req_read_i[i];
                win_wr    = req_write_i[i];
                win_addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata = req_wdata_i[i*LINE_WIDTH +: LINE_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        dn_read_d  = dn_read_q;
        dn_write_d = dn_write_q;
        dn_addr_d  = dn_addr_q;
        dn_wdata_d = dn_wdata_q;
        rdata_d    = rdata_q;
        resp_d     = '0;
        unique case (state_q)
            StIdle: begin
                if (win_vld) begin
                    state_d    = StIssue;
                    ptr_d      = win;
                    grant_d    = win;
                    // A write wins over a simultaneous read on the same port.
                    dn_write_d = win_wr;
                    dn_read_d  = win_rd & ~win_wr;
                    dn_addr_d  = win_addr;
                    dn_wdata_d = win_wdata;
                end
            end
            StIssue: begin
                if (dn_resp_i) begin
                    state_d    = StDone;
                    dn_read_d  = 1'b0;
                    dn_write_d = 1'b0;
                    if (dn_read_q) begin
                        rdata_d = dn_rdata_i;
                    end
                    for (int i = 0; i < int'(NUM_PORTS); i++) begin
                        resp_d[i] = (GW'(i) == grant_q);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            ptr_q      <= GW'(NUM_PORTS - 1);
            grant_q    <= '0;
            dn_read_q  <= 1'b0;
            dn_write_q <= 1'b0;
            dn_addr_q  <= '0;
            dn_wdata_q <= '0;
            rdata_q    <= '0;
            resp_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            dn_read_q  <= dn_read_d;
            dn_write_q <= dn_write_d;
            dn_addr_q  <= dn_addr_d;
            dn_wdata_q <= dn_wdata_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
        end
    end

    assign req_resp_o  = resp_q;
    assign req_rdata_o = rdata_q;
    assign dn_read_o   = dn_read_q;
    assign dn_write_o  = dn_write_q;
    assign dn_addr_o   = dn_addr_q;
    assign dn_wdata_o  = dn_wdata_q;
    assign busy_o      = (state_q != StIdle);
    assign grant_id_o  = grant_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with identical stimulus and checks both
// against per-transaction expectations from a directed table and a randomized policy model.
module tb_l2_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int LW = 128;
    localparam int GW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_read, req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*LW-1:0]   req_wdata;
    logic [LW-1:0]     dn_rdata;
    logic              dn_resp;

    logic [N-1:0]  r_resp, f_resp;
    logic [LW-1:0] r_rdata, f_rdata, r_wdata, f_wdata;
    logic          r_rd, f_rd, r_wr, f_wr, r_busy, f_busy;
    logic [AW-1:0] r_addr, f_addr;
    logic [GW-1:0] r_gnt, f_gnt;

    always #5 clk = ~clk;

    l2_port_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .RR_MODE(1'b1)) u_rr (
        .clk_i(clk), .reset_i(reset), .req_read_i(req_read), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_resp_o(r_resp),
        .req_rdata_o(r_rdata), .dn_read_o(r_rd), .dn_write_o(r_wr), .dn_addr_o(r_addr),
        .dn_wdata_o(r_wdata), .dn_rdata_i(dn_rdata), .dn_resp_i(dn_resp), .busy_o(r_busy),
        .grant_id_o(r_gnt)
    );

    l2_port_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .RR_MODE(1'b0)) u_fp (
        .clk_i(clk), .reset_i(reset), .req_read_i(req_read), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_resp_o(f_resp),
        .req_rdata_o(f_rdata), .dn_read_o(f_rd), .dn_write_o(f_wr), .dn_addr_o(f_addr),
        .dn_wdata_o(f_wdata), .dn_rdata_i(dn_rdata), .dn_resp_i(dn_resp), .busy_o(f_busy),
        .grant_id_o(f_gnt)
    );

    typedef struct {
        logic [N-1:0]  rd;
        logic [N-1:0]  wr;
        logic [AW-1:0] base;
        logic [LW-1:0] wd;
        int            lat;
        logic [LW-1:0] rdat;
        logic [AW-1:0] alt;
        bit            keep;
        int            gr;
        int            gf;
    } vec_t;

    vec_t          tbl[12];
    int            n_vec = 0;
    int            n_bad = 0;
    int            m_ptr;
    logic [LW-1:0] er_r, er_f;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reqs(input logic [N-1:0] rd, input logic [N-1:0] wr,
                            input logic [AW-1:0] base, input logic [LW-1:0] wd);
        req_read  = rd;
        req_write = wr;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = base ^ (AW'(i) << 12);
            req_wdata[i*LW +: LW] = wd + LW'(i);
        end
    endtask

    // Policy model: round robin scans upward from the last winner; fixed picks the lowest.
    function automatic int pick(input logic [N-1:0] req, input int ptr, input bit rr);
        if (rr) begin
            for (int off = 1; off <= N; off++) begin
                if (req[(ptr + off) % N]) return (ptr + off) % N;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) return i;
            end
        end
        return -1;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, " rr idle"}, 160'({r_busy, r_resp, r_rd, r_wr}), 160'(0));
        chk({tag, " fp idle"}, 160'({f_busy, f_resp, f_rd, f_wr}), 160'(0));
    endtask

    task automatic xact(input string tag, input int gr, input int gf, input int lat,
                        input logic [LW-1:0] rdat, input logic [AW-1:0] alt, input bit keep);
        logic [AW-1:0] ar, af;
        logic [LW-1:0] wdr, wdf;
        logic [1:0]    opr, opf;
        ar  = req_addr[gr*AW +: AW];
        af  = req_addr[gf*AW +: AW];
        wdr = req_wdata[gr*LW +: LW];
        wdf = req_wdata[gf*LW +: LW];
        opr = {req_read[gr] & ~req_write[gr], req_write[gr]};
        opf = {req_read[gf] & ~req_write[gf], req_write[gf]};
        dn_resp = 1'b0;
        tick();
        if (alt != '0) req_addr[gr*AW +: AW] = alt;
        if (!keep) begin
            req_read  = '0;
            req_write = '0;
        end
        for (int c = 0; c <= lat; c++) begin
            chk({tag, " rr issue"}, 160'({r_busy, r_gnt, r_rd, r_wr, r_addr, r_resp}),
                160'({1'b1, GW'(gr), opr, ar, 4'b0}));
            chk({tag, " fp issue"}, 160'({f_busy, f_gnt, f_rd, f_wr, f_addr, f_resp}),
                160'({1'b1, GW'(gf), opf, af, 4'b0}));
            chk({tag, " rr wdata"}, 160'(r_wdata), 160'(wdr));
            chk({tag, " fp wdata"}, 160'(f_wdata), 160'(wdf));
            if (c < lat) tick();
        end
        dn_resp  = 1'b1;
        dn_rdata = rdat;
        tick();
        dn_resp  = 1'b0;
        dn_rdata = ~rdat;
        if (opr[1]) er_r = rdat;
        if (opf[1]) er_f = rdat;
        chk({tag, " rr done"}, 160'({r_busy, r_gnt, r_rd, r_wr, r_resp}),
            160'({1'b1, GW'(gr), 2'b00, 4'(1 << gr)}));
        chk({tag, " fp done"}, 160'({f_busy, f_gnt, f_rd, f_wr, f_resp}),
            160'({1'b1, GW'(gf), 2'b00, 4'(1 << gf)}));
        chk({tag, " rr rdata"}, 160'(r_rdata), 160'(er_r));
        chk({tag, " fp rdata"}, 160'(f_rdata), 160'(er_f));
        tick();
        chk_idle(tag);
    endtask

    initial begin
        logic [N-1:0] rd, wr;
        int           gr, gf;
        reset    = 1'b1;
        dn_resp  = 1'b0;
        dn_rdata = '0;
        set_reqs('0, '0, '0, '0);
        tick();
        tick();
        reset = 1'b0;
        er_r  = '0;
        er_f  = '0;
        m_ptr = N - 1;
        chk("reset rr", 160'({r_busy, r_resp, r_rd, r_wr, r_gnt, r_addr, r_wdata}), 160'(0));
        chk("reset fp", 160'({f_busy, f_resp, f_rd, f_wr, f_gnt, f_addr, f_wdata}), 160'(0));
        chk("reset rdata", 160'({r_rdata, f_rdata}), 160'(0));

        // A response with nothing outstanding must not produce a completion.
        dn_resp = 1'b1;
        tick();
        dn_resp = 1'b0;
        tick();
        chk_idle("stray resp");

        tbl[0]  = '{4'b0010, 4'b0000, 16'h0240, 128'h0, 3, {16{8'hA5}}, 16'h0, 1'b0, 1, 1};
        tbl[1]  = '{4'b0001, 4'b0001, 16'h0080, 128'h1, 0, {4{32'hDEAD0001}}, 16'h0, 1'b0, 0, 0};
        tbl[2]  = '{4'b1000, 4'b0000, 16'h3100, 128'h0, 2, {4{32'h3C3C3C3C}}, 16'h0200, 1'b0,
                    3, 3};
        for (int k = 0; k < 6; k++) begin
            tbl[3+k] = '{4'b1111, 4'b0000, 16'h0400 + 16'(k), 128'h77, 0,
                         {4{32'hC0DE0000 + 32'(k)}}, 16'h0, 1'b1, k % 4, 0};
        end
        tbl[9]  = '{4'b0101, 4'b0000, 16'h0900, 128'h9, 0, {4{32'h99}}, 16'h0, 1'b1, 2, 0};
        tbl[10] = '{4'b0101, 4'b0000, 16'h0A00, 128'hA, 1, {4{32'hAA}}, 16'h0, 1'b1, 0, 0};
        tbl[11] = '{4'b0100, 4'b0000, 16'h0B00, 128'hB, 0, {4{32'hBB}}, 16'h0, 1'b0, 2, 2};

        for (int i = 0; i < 12; i++) begin
            set_reqs(tbl[i].rd, tbl[i].wr, tbl[i].base, tbl[i].wd);
            xact($sformatf("tbl%0d", i), tbl[i].gr, tbl[i].gf, tbl[i].lat, tbl[i].rdat,
                 tbl[i].alt, tbl[i].keep);
        end

        // Reset while a read is outstanding, then a late downstream response.
        set_reqs(4'b0110, 4'b0000, 16'h0500, 128'h5);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_reqs('0, '0, '0, '0);
        chk("rst issue rr", 160'({r_busy, r_resp, r_rd, r_wr, r_gnt, r_addr, r_rdata}), 160'(0));
        chk("rst issue fp", 160'({f_busy, f_resp, f_rd, f_wr, f_gnt, f_addr, f_rdata}), 160'(0));
        dn_resp = 1'b1;
        tick();
        dn_resp = 1'b0;
        chk_idle("late resp");
        tick();
        chk_idle("late resp+1");
        er_r  = '0;
        er_f  = '0;
        set_reqs(4'b1111, 4'b0000, 16'h0600, 128'h6);
        xact("post reset", 0, 0, 0, {4{32'h600D600D}}, 16'h0, 1'b0);
        m_ptr = 0;

        for (int it = 0; it < 80; it++) begin
            rd = N'($urandom);
            wr = N'($urandom & $urandom);
            if ($urandom_range(0, 7) == 0) begin
                rd = '0;
                wr = '0;
            end
            set_reqs(rd, wr, AW'($urandom), {4{$urandom}});
            if ((rd | wr) == '0) begin
                dn_resp = 1'($urandom_range(0, 1));
                tick();
                dn_resp = 1'b0;
                chk_idle($sformatf("rnd%0d none", it));
                continue;
            end
            gr = pick(rd | wr, m_ptr, 1'b1);
            gf = pick(rd | wr, 0, 1'b0);
            xact($sformatf("rnd%0d", it), gr, gf, $urandom_range(0, 3), {4{$urandom}},
                 ($urandom_range(0, 1) == 1) ? AW'($urandom_range(1, 65535)) : AW'(0),
                 1'($urandom_range(0, 1)));
            m_ptr = gr;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
